// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encodings, header length and byte-lane width.
package imem_loader_pkg;

  localparam int HDR_BYTES = 2;
  localparam int LANE_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word; the fourth
// byte is merged combinationally so the word is ready on the lane-3 transfer.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [LANE_W-1:0] byte_data,
  output logic [31:0]       word,
  output logic              word_complete
);

  logic [1:0]  lane;
  logic [23:0] lanes_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane    <= 2'd0;
      lanes_q <= 24'd0;
    end else if (load) begin
      case (lane)
        2'd0:    lanes_q[LANE_W-1:0]          <= byte_data;
        2'd1:    lanes_q[2*LANE_W-1:LANE_W]   <= byte_data;
        2'd2:    lanes_q[3*LANE_W-1:2*LANE_W] <= byte_data;
        default: lanes_q                      <= lanes_q;
      endcase
      lane <= lane + 2'd1;
    end
  end

  assign word_complete = load && (lane == 2'd3);
  assign word          = {byte_data, lanes_q};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian instruction image into instruction
// memory and holds the core in reset until the whole image is written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output state_t                dbg_state
);

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
  // byte_ready is registered and high only in LEN0, LEN1 and DATA.

  localparam int CW = HDR_BYTES * LANE_W;

  state_t                state;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] index;
  logic [CW-1:0]         full_count;
  logic                  xfer;
  logic                  restart;
  logic                  last_word;
  logic [31:0]           word;
  logic                  word_complete;

  assign xfer       = byte_valid && byte_ready;
  assign full_count = {byte_data, count[LANE_W-1:0]};
  assign restart    = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign last_word  = (32'(index) == 32'(count) - 32'd1);
  assign dbg_state  = state;

  word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (restart),
    .load          (xfer && state == S_DATA),
    .byte_data     (byte_data),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      index      <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LEN0: begin
          if (xfer) begin
            count[LANE_W-1:0] <= byte_data;
            state             <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            count <= full_count;
            if (int'(full_count) > MAX_WORDS) begin
              state      <= S_ERR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else if (full_count == '0) begin
              state      <= S_DONE;
              byte_ready <= 1'b0;
              done       <= 1'b1;
              cpu_reset  <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_complete) begin
            imem_we    <= 1'b1;
            imem_addr  <= index;
            imem_wdata <= word;
            index      <= index + 1'b1;
            // Final write and DONE land in the same cycle.
            if (last_word) begin
              state      <= S_DONE;
              byte_ready <= 1'b0;
              done       <= 1'b1;
              cpu_reset  <= 1'b0;
            end
          end
        end
        default: begin
          if (restart) begin
            state      <= S_LEN0;
            index      <= '0;
            byte_ready <= 1'b1;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/data streams at full rate and with
// gaps, zero/oversize/maximum headers, reset mid-load and reload.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int w0;
  logic last_w_done;
  logic last_w_cpurst;
  logic [39:0] exp_q[$];
  logic [7:0]  img_q[$];

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the head of exp_q
  always @(negedge clk) begin
    logic [39:0] e;
    if (!reset && imem_we) begin
      we_count++;
      last_w_done   = done;
      last_w_cpurst = cpu_reset;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e[39:32]));
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 16) begin
      tick();
      n++;
    end
    if (!byte_ready) begin
      check("byte_ready_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b0;
      return;
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_img(input int gap);
    for (int i = 0; i < img_q.size(); i++) begin
      send_byte(img_q[i]);
      if (i != img_q.size() - 1)
        repeat (gap) tick();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;

    // Idle with start low
    repeat (10) tick();
    check("idle_byte_ready", 32'(byte_ready), 32'd0);
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    check("idle_done", 32'(done), 32'd0);
    check("idle_we_count", 32'(we_count), 32'd0);

    // Two-word load at full rate
    exp_q.push_back({8'd0, 32'h0050_0093});
    exp_q.push_back({8'd1, 32'h00A0_0113});
    img_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    start_pulse();
    check("full_state_len0", 32'(dbg_state), 32'(S_LEN0));
    check("full_byte_ready", 32'(byte_ready), 32'd1);
    send_img(0);
    check("full_last_we", 32'(imem_we), 32'd1);
    check("full_last_addr", 32'(imem_addr), 32'd1);
    check("full_last_wdata", imem_wdata, 32'h00A0_0113);
    check("full_done", 32'(done), 32'd1);
    check("full_cpu_reset", 32'(cpu_reset), 32'd0);
    check("full_state_done", 32'(dbg_state), 32'(S_DONE));
    tick();
    check("full_we_drop", 32'(imem_we), 32'd0);
    check("full_byte_ready_drop", 32'(byte_ready), 32'd0);
    check("full_we_count", 32'(we_count), 32'd2);
    check("full_exp_empty", 32'(exp_q.size()), 32'd0);

    // Same image, three idle cycles between bytes
    w0 = we_count;
    exp_q.push_back({8'd0, 32'h0050_0093});
    exp_q.push_back({8'd1, 32'h00A0_0113});
    start_pulse();
    check("stall_done_clear", 32'(done), 32'd0);
    check("stall_cpu_reset", 32'(cpu_reset), 32'd1);
    send_img(3);
    check("stall_last_we", 32'(imem_we), 32'd1);
    check("stall_done", 32'(done), 32'd1);
    tick();
    check("stall_we_count", 32'(we_count - w0), 32'd2);
    check("stall_exp_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length header
    w0 = we_count;
    img_q = '{8'h00, 8'h00};
    start_pulse();
    send_img(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    check("zero_byte_ready", 32'(byte_ready), 32'd0);
    tick();
    check("zero_we_count", 32'(we_count - w0), 32'd0);

    // Oversize header: 257 words
    img_q = '{8'h01, 8'h01};
    start_pulse();
    send_img(0);
    check("over_error", 32'(error), 32'd1);
    check("over_cpu_reset", 32'(cpu_reset), 32'd1);
    check("over_byte_ready", 32'(byte_ready), 32'd0);
    check("over_done", 32'(done), 32'd0);
    check("over_state", 32'(dbg_state), 32'(S_ERR));

    // Maximum legal image: 256 words, last write at address 255
    w0 = we_count;
    img_q = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      img_q.push_back(8'(i));
      img_q.push_back(8'h5A);
      img_q.push_back(8'(255 - i));
      img_q.push_back(8'h01);
      exp_q.push_back({8'(i), 8'h01, 8'(255 - i), 8'h5A, 8'(i)});
    end
    start_pulse();
    check("max_error_clear", 32'(error), 32'd0);
    send_img(0);
    check("max_last_addr", 32'(imem_addr), 32'd255);
    check("max_last_wdata", imem_wdata, 32'h0100_5AFF);
    check("max_done", 32'(done), 32'd1);
    tick();
    check("max_we_count", 32'(we_count - w0), 32'd256);
    check("max_exp_empty", 32'(exp_q.size()), 32'd0);

    // Reset after the second byte of word 1
    img_q = '{8'h02, 8'h00, 8'h93, 8'h00};
    start_pulse();
    send_img(0);
    reset = 1'b1;
    tick();
    check_reset_values("midreset");
    reset = 1'b0;
    tick();
    exp_q.push_back({8'd0, 32'h0050_0093});
    exp_q.push_back({8'd1, 32'h00A0_0113});
    img_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    start_pulse();
    send_img(0);
    check("after_reset_done", 32'(done), 32'd1);
    tick();
    check("after_reset_exp_empty", 32'(exp_q.size()), 32'd0);
    check("after_reset_last_cpurst", 32'(last_w_cpurst), 32'd0);

    // Reload from DONE with a one-word image
    w0 = we_count;
    start_pulse();
    check("reload_done_clear", 32'(done), 32'd0);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    exp_q.push_back({8'd0, 32'h0000_006F});
    img_q = '{8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_img(0);
    check("reload_addr", 32'(imem_addr), 32'd0);
    check("reload_wdata", imem_wdata, 32'h0000_006F);
    tick();
    check("reload_we_count", 32'(we_count - w0), 32'd1);
    check("reload_last_done", 32'(last_w_done), 32'd1);
    check("reload_exp_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
